// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package booth_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } booth_state_t;

   // Booth operation chosen from the multiplier bit pair {Q[0], Q_-1}.
   localparam logic [1:0] SEL_NOP = 2'b00;
   localparam logic [1:0] SEL_ADD = 2'b01;
   localparam logic [1:0] SEL_SUB = 2'b10;

   // Map the examined bit pair to the accumulator operation.
   function automatic logic [1:0] booth_sel(input logic q0, input logic q_m1);
      logic [1:0] sel;
      case ({q0, q_m1})
         2'b01:   sel = SEL_ADD;
         2'b10:   sel = SEL_SUB;
         default: sel = SEL_NOP;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic right shift of {A,Q,Q_-1}.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   a_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic             q_m1_in,
   input  logic [WIDTH:0]   m_in,
   output logic [WIDTH:0]   a_out,
   output logic [WIDTH-1:0] q_out,
   output logic             q_m1_out
);

   logic [1:0]   sel;
   logic [WIDTH:0] sum;

   // Accumulate: A, A+M or A-M, all modulo 2^(WIDTH+1); the extra bit keeps -2^(WIDTH-1) exact.
   always_comb begin
      sel = booth_sel(q_in[0], q_m1_in);
      sum = a_in;
      case (sel)
         SEL_ADD: sum = a_in + m_in;
         SEL_SUB: sum = a_in - m_in;
         default: sum = a_in;
      endcase
   end

   // Arithmetic shift right by one across the {A,Q,Q_-1} chain, replicating the sign of A.
   always_comb begin
      a_out    = {sum[WIDTH], sum[WIDTH:1]};
      q_out    = {sum[0], q_in[WIDTH-1:1]};
      q_m1_out = q_in[0];
   end

endmodule

// File: rtl/booth_mult_core.sv
// Sequential radix-2 Booth multiplier: captures signed operands on start, WIDTH iterations, registered 2*WIDTH product.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; minimum issue interval WIDTH+2 cycles.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped (no queuing).
module booth_mult_core
   import booth_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   booth_state_t      state;
   logic [WIDTH:0]    a_reg;
   logic [WIDTH-1:0]  q_reg;
   logic              q_m1_reg;
   logic [WIDTH:0]    m_reg;
   logic [CNT_W-1:0]  count;

   logic [WIDTH:0]    a_nx;
   logic [WIDTH-1:0]  q_nx;
   logic              q_m1_nx;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .a_in     (a_reg),
      .q_in     (q_reg),
      .q_m1_in  (q_m1_reg),
      .m_in     (m_reg),
      .a_out    (a_nx),
      .q_out    (q_nx),
      .q_m1_out (q_m1_nx)
   );

   // Control FSM and datapath registers; the product is captured from the final iteration's result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         a_reg    <= '0;
         q_reg    <= '0;
         q_m1_reg <= 1'b0;
         m_reg    <= '0;
         count    <= '0;
         product  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg    <= '0;
                  q_reg    <= multiplier;
                  q_m1_reg <= 1'b0;
                  m_reg    <= {multiplicand[WIDTH-1], multiplicand};
                  count    <= CNT_W'(WIDTH);
                  state    <= CALC;
               end
            end
            CALC: begin
               a_reg    <= a_nx;
               q_reg    <= q_nx;
               q_m1_reg <= q_m1_nx;
               count    <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  // A's guard bit is only the sign; the full product fits in the low WIDTH bits of A plus Q.
                  product <= {a_nx[WIDTH-1:0], q_nx};
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status flags decode straight from the registered state so start never reaches them combinationally.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

endmodule

// File: tb/tb_booth_mult_core.sv
module tb_booth_mult_core;

   localparam int W = 16;

   logic           clk;
   logic           reset;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int n_cmp;
   int n_fail;

   booth_mult_core #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for one cycle; returns just after the accepting edge.
   task automatic do_start(input logic [W-1:0] m, input logic [W-1:0] q);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      step();
      start        = 1'b0;
   endtask

   // Wait for done (bounded). lat counts cycles after the accepting edge, first cycle = 1.
   task automatic wait_done(output int lat, output int busy_cnt, output bit timed_out);
      int n;
      n = 1;
      busy_cnt = 0;
      timed_out = 1'b0;
      forever begin
         if (busy) busy_cnt++;
         if (done) break;
         if (n >= 100) begin
            timed_out = 1'b1;
            break;
         end
         step();
         n++;
      end
      lat = n;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      repeat (3) step();
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++;
      if (product !== 32'h0) begin n_fail++; $display("FAIL reset_product: got %h want 0", product); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic;
      int lat, bc;
      bit to;
      do_start(16'd3, 16'd5);
      wait_done(lat, bc, to);
      n_cmp++;
      if (to || lat != 17) begin n_fail++; $display("FAIL basic_latency: got %0d (timeout=%0d) want 17", lat, to); end
      n_cmp++;
      if (bc != 17) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
      n_cmp++;
      if (product !== 32'h0000000F) begin n_fail++; $display("FAIL basic_product: got %h want 0000000f", product); end
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after_done: done=%b busy=%b want 0 0", done, busy); end
      n_cmp++;
      if (product !== 32'h0000000F) begin n_fail++; $display("FAIL basic_hold_idle: got %h want 0000000f", product); end
   endtask

   task automatic test_signed;
      int lat, bc;
      bit to;
      logic [W-1:0]   tm [3];
      logic [W-1:0]   tq [3];
      logic [2*W-1:0] te [3];
      tm[0] = 16'hFFFD; tq[0] = 16'h0005; te[0] = 32'hFFFFFFF1;
      tm[1] = 16'h8000; tq[1] = 16'h8000; te[1] = 32'h40000000;
      tm[2] = 16'h8000; tq[2] = 16'h7FFF; te[2] = 32'hC0008000;
      for (int i = 0; i < 3; i++) begin
         do_start(tm[i], tq[i]);
         // Later operand changes must not matter.
         multiplicand = 16'h1234;
         multiplier   = 16'h4321;
         wait_done(lat, bc, to);
         n_cmp++;
         if (to || product !== te[i]) begin
            n_fail++;
            $display("FAIL signed_%0d: got %h want %h (timeout=%0d)", i, product, te[i], to);
         end
         step();
      end
   endtask

   task automatic test_ignore_start;
      int dcnt, lat, bc;
      bit to;
      dcnt = 0;
      do_start(16'd7, 16'd9);
      for (int n = 1; n <= 30; n++) begin
         if (n == 5) begin
            multiplicand = 16'd1;
            multiplier   = 16'd1;
            start        = 1'b1;
         end else begin
            start = done;
         end
         if (done) dcnt++;
         step();
      end
      start = 1'b0;
      n_cmp++;
      if (dcnt != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", dcnt); end
      n_cmp++;
      if (product !== 32'd63) begin n_fail++; $display("FAIL ignore_product: got %h want 0000003f", product); end
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: busy=%b want 0", busy); end
      do_start(16'd1, 16'd1);
      wait_done(lat, bc, to);
      n_cmp++;
      if (to || product !== 32'd1) begin n_fail++; $display("FAIL ignore_next: got %h want 00000001", product); end
      step();
   endtask

   task automatic test_reset_mid;
      int dcnt, lat, bc;
      bit to;
      dcnt = 0;
      do_start(16'h0123, 16'h0456);
      repeat (7) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: busy=%b done=%b want 0 0", busy, done); end
      n_cmp++;
      if (product !== 32'h0) begin n_fail++; $display("FAIL midreset_product: got %h want 0", product); end
      for (int n = 0; n < 30; n++) begin
         if (done) dcnt++;
         step();
      end
      n_cmp++;
      if (dcnt != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d want 0", dcnt); end
      do_start(16'hFFFF, 16'hFFFF);
      wait_done(lat, bc, to);
      n_cmp++;
      if (to || product !== 32'd1) begin n_fail++; $display("FAIL midreset_fresh: got %h want 00000001", product); end
      step();
   endtask

   task automatic test_back_to_back;
      logic signed [W-1:0]   sm, sq;
      logic signed [2*W-1:0] sp;
      logic [2*W-1:0] held;
      int  cyc, last_done, ops, bad_prod, bad_int, bad_stab;
      bit  have, stable;
      ops = 0; cyc = 0; have = 1'b0; stable = 1'b1;
      bad_prod = 0; bad_int = 0; bad_stab = 0; last_done = 0; held = '0;
      sm = W'($urandom); sq = W'($urandom); sp = sm * sq;
      multiplicand = sm; multiplier = sq;
      start = 1'b1;
      step();
      cyc = 1;
      while (ops < 1000 && cyc < 25000) begin
         if (done) begin
            n_cmp++;
            if (product !== sp) begin
               n_fail++; bad_prod++;
               if (bad_prod <= 5) $display("FAIL b2b_product op %0d: got %h want %h", ops, product, sp);
            end
            if (have) begin
               n_cmp++;
               if (cyc - last_done != 18) begin
                  n_fail++; bad_int++;
                  if (bad_int <= 5) $display("FAIL b2b_interval op %0d: got %0d want 18", ops, cyc - last_done);
               end
               n_cmp++;
               if (!stable) begin
                  n_fail++; bad_stab++;
                  if (bad_stab <= 5) $display("FAIL b2b_stable op %0d: product changed between done pulses, want held %h", ops, held);
               end
            end
            last_done = cyc; held = product; have = 1'b1; stable = 1'b1; ops++;
            sm = W'($urandom); sq = W'($urandom); sp = sm * sq;
            multiplicand = sm; multiplier = sq;
         end else if (have && product !== held) begin
            stable = 1'b0;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      n_cmp++;
      if (ops != 1000) begin n_fail++; $display("FAIL b2b_timeout: got %0d ops want 1000", ops); end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      test_reset();
      test_basic();
      test_signed();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/booth_mult_core.md
Name: booth_mult_core

Overview:
- Sequential radix-2 Booth multiplier engine, directly downstream of the operand input registers.
- Samples the two signed operands on a start pulse and runs one Booth iteration per clock for WIDTH cycles.
- Presents the 2*WIDTH-bit signed product with a one-cycle done pulse.
- Product is held stable until the next accepted start; a result/output stage consumes it.

Parameters:
WIDTH, 16, operand width in bits (two's complement); must be >= 2.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request to begin a multiplication; honoured only in IDLE.
multiplicand  input  WIDTH  signed operand M, sampled on accepted start.
multiplier  input  WIDTH  signed operand Q, sampled on accepted start.
busy  output  1  high in CALC and DONE states.
done  output  1  one-cycle pulse; product valid from this cycle.
product  output  2*WIDTH  signed product M*Q, registered.

Behaviour:
- Interface: reset is synchronous, active-high; the clock is clk.
- Reset values: state=IDLE, busy=0, done=0, product=0. Internal A, Q, Q_-1, M and count are all cleared.
- Reset mid-operation aborts the multiplication. product returns to 0 and no done pulse is produced.
- Registers:
  - A: WIDTH+1 bits. The extra bit absorbs overflow when M = -2^(WIDTH-1).
  - Q: WIDTH bits.
  - Q_-1: 1 bit.
  - M: WIDTH+1 bits, sign-extended from multiplicand.
  - count: CNT_W bits.
- IDLE:
  - busy=0, done=0.
  - If start=1 at a clock edge: A<=0, Q<=multiplier, Q_-1<=0, M<=sext(multiplicand), count<=WIDTH, go to CALC.
  - Operands are captured only at this edge; later operand changes have no effect.
- CALC, one iteration per cycle:
  - Step 1, select on {Q[0],Q_-1}:
    - 00 or 11: A unchanged.
    - 01: A = A + M.
    - 10: A = A - M.
    - Arithmetic is mod 2^(WIDTH+1).
  - Step 2, arithmetic right shift of {A,Q,Q_-1} by 1. The MSB of A is replicated.
  - Then count <= count-1. When the current count==1, go to DONE.
  - Exactly WIDTH CALC cycles.
- DONE:
  - product <= {A[WIDTH-1:0], Q} at the edge entering DONE.
  - done=1 for exactly this one cycle, busy=1, then return to IDLE.
- Latency:
  - Start accepted at edge k.
  - CALC occupies cycles k+1..k+WIDTH.
  - done and a valid product appear in cycle k+WIDTH+1.
  - Next start can be accepted at the edge ending the DONE cycle + 1, i.e. in IDLE. Minimum issue interval is WIDTH+2 cycles.
- start while busy=1, including in the DONE cycle, is ignored. No queuing and no error flag.
- start held high continuously: a new operation is accepted each time the block is in IDLE.
- product is held unchanged in IDLE and CALC until the next DONE overwrites it.
- done and busy are decoded from the registered state (no combinational path from start).

Decomposition:
- Package booth_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t.
  - localparam DEFAULT_WIDTH = 16.
  - Booth select encoding constants (NOP, ADD, SUB).
- Sub-module booth_step (combinational):
  - Inputs A, Q, Q_-1, M.
  - Outputs next A, Q, Q_-1 after add/sub and arithmetic shift.
  - Keeps the FSM/register logic in booth_mult_core separate from the arithmetic.

Test Plan:
- Reset, then start with M=3, Q=5 -> done pulses exactly 17 cycles after the start edge; product=0x0000000F; busy high for 17 cycles.
- M=-3 (0xFFFD), Q=5 -> product=0xFFFFFFF1.
- M=0x8000, Q=0x8000 -> product=0x40000000, which checks the A extra bit. Also M=0x8000, Q=0x7FFF -> product=0xC0008000.
- Start with M=7, Q=9; pulse start again with M=1, Q=1 at cycles 5 and at the DONE cycle -> only product=63 is produced, with a single done. The next start in IDLE yields 1.
- Assert reset in cycle 8 of a CALC run -> the next cycle shows busy=0, done=0, product=0, and no done ever follows. A fresh start with M=-1, Q=-1 gives product=1.
- Random signed operands, 1000 back-to-back starts held high -> every product matches the signed reference model; issue interval is 18 cycles; product is stable between done pulses.
